// File: rtl/switch_debounce.sv
// switch_debounce
// Brings the raw slide switches into the clock domain and debounces them.
// Every switch goes through a two-flop synchroniser and is then sampled on a
// shared prescaled tick. A debounced bit only changes after STABLE_TICKS
// consecutive tick samples agree. The block also produces one-cycle
// rise/fall/change strobes so downstream logic needs no edge detectors.
//
// Optional feature: define DEBOUNCE_EDGE_COUNT_EN to add EDGE_COUNT_O, a
// 16-bit wrapping count of rising edges on debounced bit 0.
module switch_debounce #(
  parameter int NUM_SW       = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic              CLOCK_50_I,
  input  logic              RESETN_I,
  input  logic [NUM_SW-1:0] SWITCH_I,
  output logic [NUM_SW-1:0] SWITCH_O,
  output logic [NUM_SW-1:0] RISE_O,
  output logic [NUM_SW-1:0] FALL_O,
  output logic              CHANGE_O,
  output logic              TICK_O
`ifdef DEBOUNCE_EDGE_COUNT_EN
  ,
  output logic [15:0]       EDGE_COUNT_O
`endif
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;

  logic [CNT_W-1:0]  prescale_q;
  logic [CNT_W-1:0]  prescale_d;
  logic              tick;

  logic [NUM_SW-1:0][STABLE_TICKS-1:0] hist_q;
  logic [NUM_SW-1:0][STABLE_TICKS-1:0] hist_d;

  logic [NUM_SW-1:0] sw_q;
  logic [NUM_SW-1:0] sw_d;
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] rise_d;
  logic [NUM_SW-1:0] fall_q;
  logic [NUM_SW-1:0] fall_d;
  logic              change_q;
  logic              change_d;

  // Two-flop synchroniser; the raw switches are asynchronous to the clock.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SWITCH_I;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next state: count 0..TICK_DIV-1, tick on the last count.
  always_comb begin
    tick       = (prescale_q == TICK_LAST);
    prescale_d = prescale_q + CNT_W'(1);
    if (tick) begin
      prescale_d = '0;
    end
  end

  // Prescaler register; reset restarts the tick phase from zero.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  // History next state: shift in the synchronised level only on a tick.
  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      for (int i = 0; i < NUM_SW; i++) begin
        hist_d[i] = {hist_q[i][STABLE_TICKS-2:0], sync2_q[i]};
      end
    end
  end

  // History shift registers, one per switch.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Debounce decision: a uniform history that disagrees with the current
  // level flips it; any mixed history holds the level and rejects bounce.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      rise_d[i] = (&hist_q[i]) & ~sw_q[i];
      fall_d[i] = ~(|hist_q[i]) & sw_q[i];
    end
    sw_d     = (sw_q | rise_d) & ~fall_d;
    change_d = |(rise_d | fall_d);
  end

  // Debounced levels and their one-cycle strobes, all registered together.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      sw_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sw_q     <= sw_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

`ifdef DEBOUNCE_EDGE_COUNT_EN
  logic [15:0] edgeCnt_q;
  logic [15:0] edgeCnt_d;

  // Edge counter next state: bump alongside the RISE_O[0] strobe, wraps.
  always_comb begin
    edgeCnt_d = edgeCnt_q + {15'b0, rise_d[0]};
  end

  // Edge counter register.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      edgeCnt_q <= '0;
    end else begin
      edgeCnt_q <= edgeCnt_d;
    end
  end

  assign EDGE_COUNT_O = edgeCnt_q;
`endif

  assign SWITCH_O = sw_q;
  assign RISE_O   = rise_q;
  assign FALL_O   = fall_q;
  assign CHANGE_O = change_q;
  assign TICK_O   = tick;

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
// Scoreboard bench for switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Every stimulus that should move a debounced bit pushes the expected
// debounced word and strobes onto a queue; a monitor pops one entry per
// CHANGE_O pulse and checks values and latency. Build with
// DEBOUNCE_EDGE_COUNT_EN defined to also exercise the edge counter.
module tb_switch_debounce;

  localparam int NUM_SW       = 18;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LAT_MIN      = (STABLE_TICKS - 1) * TICK_DIV + 3;
  localparam int LAT_MAX      = STABLE_TICKS * TICK_DIV + 2;

  typedef struct {
    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;
    int                driveCnt;
    logic [15:0]       edges;
  } expItem_t;

  logic              clock   = 1'b0;
  logic              resetnI = 1'b0;
  logic [NUM_SW-1:0] switchI = '1;
  logic [NUM_SW-1:0] switchO;
  logic [NUM_SW-1:0] riseO;
  logic [NUM_SW-1:0] fallO;
  logic              changeO;
  logic              tickO;
`ifdef DEBOUNCE_EDGE_COUNT_EN
  logic [15:0]       edgeCountO;
`endif

  expItem_t          sbQueue[$];
  expItem_t          monItem;
  int                monLat;
  int                total     = 0;
  int                bad       = 0;
  int                edgeCnt   = 0;
  logic [NUM_SW-1:0] modelSw   = '0;
  logic [15:0]       modelEdges = '0;

  switch_debounce #(
    .NUM_SW      (NUM_SW),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .CLOCK_50_I  (clock),
    .RESETN_I    (resetnI),
    .SWITCH_I    (switchI),
    .SWITCH_O    (switchO),
    .RISE_O      (riseO),
    .FALL_O      (fallO),
    .CHANGE_O    (changeO),
    .TICK_O      (tickO)
`ifdef DEBOUNCE_EDGE_COUNT_EN
    ,
    .EDGE_COUNT_O(edgeCountO)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCnt = edgeCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
    end
  endtask

  // Record what the debounced word must become after moving to target.
  task automatic pushExpect(input logic [NUM_SW-1:0] target);
    expItem_t item;
    item.sw       = target;
    item.rise     = target & ~modelSw;
    item.fall     = ~target & modelSw;
    item.driveCnt = edgeCnt;
    if (item.rise[0]) modelEdges = modelEdges + 16'd1;
    item.edges    = modelEdges;
    if ((item.rise | item.fall) != '0) sbQueue.push_back(item);
    modelSw = target;
  endtask

  task automatic applyStimulus(input logic [NUM_SW-1:0] target);
    @(negedge clock);
    switchI = target;
    pushExpect(target);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(sbQueue.size()), 32'h0);
    if (sbQueue.size() != 0) sbQueue.delete();
    repeat (3) @(negedge clock);
  endtask

  // Hold reset for some cycles with the switches at 'held', then release.
  task automatic resetSequence(input logic [NUM_SW-1:0] held, input int cycles);
    @(negedge clock);
    resetnI = 1'b0;
    switchI = held;
    repeat (cycles) begin
      @(negedge clock);
      checkOutput("rstSw", 32'(switchO), 32'h0);
      checkOutput("rstRise", 32'(riseO), 32'h0);
      checkOutput("rstChange", 32'(changeO), 32'h0);
    end
    modelSw    = '0;
    modelEdges = '0;
    resetnI    = 1'b1;
    pushExpect(held);
    @(negedge clock);
    checkOutput("postRstSw", 32'(switchO), 32'h0);
    checkOutput("postRstRise", 32'(riseO), 32'h0);
    checkOutput("postRstChange", 32'(changeO), 32'h0);
  endtask

  // Monitor: each CHANGE_O pulse consumes exactly one expected entry.
  always @(negedge clock) begin
    if (changeO === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedChange", 32'h1, 32'h0);
      end else begin
        monItem = sbQueue.pop_front();
        monLat  = edgeCnt - monItem.driveCnt - 1;
        checkOutput("sw", 32'(switchO), 32'(monItem.sw));
        checkOutput("rise", 32'(riseO), 32'(monItem.rise));
        checkOutput("fall", 32'(fallO), 32'(monItem.fall));
        checkOutput($sformatf("latency=%0d inRange", monLat),
                    32'(monLat >= LAT_MIN && monLat <= LAT_MAX), 32'h1);
`ifdef DEBOUNCE_EDGE_COUNT_EN
        if (monItem.rise[0]) checkOutput("edgeCount", 32'(edgeCountO), 32'(monItem.edges));
`endif
      end
    end else if (resetnI === 1'b1 && (riseO | fallO) != '0) begin
      checkOutput("strayStrobe", 32'(riseO | fallO), 32'h0);
    end
  end

  initial begin
    int seen;
    int period;

    $display("[TB] reset with all switches high");
    resetSequence('1, 3);
    waitDrain("drainResetRise");

    $display("[TB] tick period");
    repeat (2) begin
      seen = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin
        @(negedge clock);
        if (tickO === 1'b1) seen = 1;
      end
      period = 0;
      seen   = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin
        @(negedge clock);
        period++;
        if (tickO === 1'b1) seen = 1;
      end
      checkOutput("tickPeriod", 32'(period), 32'd4);
    end

    applyStimulus('0);
    waitDrain("drainAllFall");

    $display("[TB] single switch rise");
    applyStimulus(18'h00001);
    waitDrain("drainSingleRise");

    $display("[TB] glitch on switch 1");
    @(negedge clock);
    switchI = modelSw | 18'h00002;
    repeat (5) @(negedge clock);
    switchI = modelSw;
    repeat (30) @(negedge clock);
    checkOutput("glitchSw1", 32'(switchO[1]), 32'h0);
    checkOutput("glitchSwAll", 32'(switchO), 32'(modelSw));

    $display("[TB] several bits together");
    applyStimulus(18'h0000E);
    waitDrain("drainMulti");

    $display("[TB] reset mid-debounce");
    applyStimulus('0);
    waitDrain("drainMultiFall");
    @(negedge clock);
    switchI = 18'h00001;
    @(negedge clock);
    seen = 0;
    for (int n = 0; n < 20 && seen < 2; n++) begin
      @(negedge clock);
      if (tickO === 1'b1) seen++;
    end
    checkOutput("preRstTicks", 32'(seen), 32'd2);
    resetSequence(18'h00001, 3);
    waitDrain("drainRstMid");

`ifdef DEBOUNCE_EDGE_COUNT_EN
    $display("[TB] edge counter");
    resetSequence('0, 3);
    repeat (3) begin
      applyStimulus(18'h00001);
      waitDrain("drainEdgeRise");
      repeat (5) @(negedge clock);
      applyStimulus('0);
      waitDrain("drainEdgeFall");
      repeat (5) @(negedge clock);
    end
    checkOutput("edgeCountThree", 32'(edgeCountO), 32'd3);
    @(negedge clock);
    force dut.edgeCnt_q = 16'hFFFF;
    @(posedge clock);
    #1;
    release dut.edgeCnt_q;
    modelEdges = 16'hFFFF;
    applyStimulus(18'h00001);
    waitDrain("drainEdgeWrap");
    checkOutput("edgeWrap", 32'(edgeCountO), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
